// File: rtl/pixel_sched_pkg.sv
// Shared types and constants for the pixel-upload frame scheduler.
// Burst-to-byte scaling for the DMA size field lives here with the state type.
package pixel_sched_pkg;

    localparam int CNT_W_DEFAULT    = 24;
    localparam int BURST_SHIFT_WORD = 5;
    localparam int BURST_SHIFT_BYTE = 7;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        RUN,
        DRAIN,
        STOPPING,
        ERROR
    } sched_state_t;

    function automatic logic [31:0] frame_size(
        input logic [31:0] bursts,
        input logic        word_mode
    );
        return word_mode ? (bursts << BURST_SHIFT_WORD)
                         : (bursts << BURST_SHIFT_BYTE);
    endfunction

endpackage

// File: rtl/pixel_frame_scheduler.sv
// Per-frame sequencer for the pixel-upload DMA: double-buffered bases,
// frame_start gating, burst counting and sticky overrun/error reporting.
module pixel_frame_scheduler
    import pixel_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      cfg_buf0_addr,
    input  logic [31:0]      cfg_buf1_addr,
    input  logic [CNT_W-1:0] cfg_frame_bursts,
    input  logic [9:0]       cfg_threshold,
    input  logic             cfg_transform,
    input  logic             cfg_word_mode,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic             cmd_swap,
    input  logic             cmd_err_clr,
    input  logic             frame_start,
    input  logic             dma_active,
    input  logic             dma_read_error,
    output logic             dma_enable,
    output logic [31:0]      dma_base_address,
    output logic [31:0]      dma_total_size,
    output logic [9:0]       dma_threshold,
    output logic             dma_transform,
    output logic             dma_word_mode,
    output logic             cur_buf,
    output logic             frame_done,
    output logic             overrun,
    output logic             err,
    output logic             busy
);

    sched_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] bursts_q;
    logic             active_q;
    logic             swap_pend;
    logic             rise;
    logic             live;
    logic             settled;
    logic             nbuf;

    assign cnt_inc = cnt + CNT_W'(1);
    assign rise    = dma_active & ~active_q;
    assign live    = (state == RUN) || (state == DRAIN) || (state == STOPPING);
    assign settled = (state == IDLE) || (state == WAIT_FRAME);
    assign nbuf    = cur_buf ^ cmd_swap;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            bursts_q         <= '0;
            active_q         <= 1'b0;
            swap_pend        <= 1'b0;
            dma_enable       <= 1'b0;
            dma_base_address <= '0;
            dma_total_size   <= '0;
            dma_threshold    <= '0;
            dma_transform    <= 1'b0;
            dma_word_mode    <= 1'b0;
            cur_buf          <= 1'b0;
            frame_done       <= 1'b0;
            overrun          <= 1'b0;
            err              <= 1'b0;
        end else begin
            active_q   <= dma_active;
            frame_done <= 1'b0;
            if (!settled && cmd_swap)
                swap_pend <= 1'b1;
            if (live && frame_start)
                overrun <= 1'b1;

            if (live && dma_read_error) begin
                dma_enable <= 1'b0;
                err        <= 1'b1;
                state      <= ERROR;
            end else if ((state == RUN || state == DRAIN) && cmd_stop) begin
                dma_enable <= 1'b0;
                state      <= STOPPING;
            end else begin
                unique case (state)
                    IDLE: begin
                        cur_buf <= nbuf;
                        if (cmd_err_clr) begin
                            err     <= 1'b0;
                            overrun <= 1'b0;
                        end
                        if (cmd_start) begin
                            if (cfg_frame_bursts == '0)
                                err <= 1'b1;
                            else
                                state <= WAIT_FRAME;
                        end
                    end
                    WAIT_FRAME: begin
                        cur_buf <= nbuf;
                        if (cmd_stop) begin
                            state <= IDLE;
                        end else if (frame_start) begin
                            // A swap landing on this edge already selects the new buffer
                            dma_base_address <= nbuf ? cfg_buf1_addr
                                                     : cfg_buf0_addr;
                            dma_total_size   <= frame_size(32'(cfg_frame_bursts),
                                                           cfg_word_mode);
                            dma_threshold    <= cfg_threshold;
                            dma_transform    <= cfg_transform;
                            dma_word_mode    <= cfg_word_mode;
                            bursts_q         <= cfg_frame_bursts;
                            cnt              <= '0;
                            dma_enable       <= 1'b1;
                            state            <= RUN;
                        end
                    end
                    RUN: begin
                        if (rise) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == bursts_q) begin
                                dma_enable <= 1'b0;
                                state      <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (!dma_active) begin
                            frame_done <= 1'b1;
                            if (swap_pend || cmd_swap)
                                cur_buf <= ~cur_buf;
                            swap_pend  <= 1'b0;
                            state      <= WAIT_FRAME;
                        end
                    end
                    STOPPING: begin
                        if (!dma_active)
                            state <= IDLE;
                    end
                    ERROR: begin
                        if (cmd_err_clr && !dma_active) begin
                            err     <= 1'b0;
                            overrun <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_scheduler.sv
// Bench for pixel_frame_scheduler: vector table, directed frame sequences,
// and a random run against a behavioural frame model.
module tb_pixel_frame_scheduler;

    localparam int CNT_W = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [31:0]      b0, b1;
    logic [CNT_W-1:0] bursts;
    logic [9:0]       thr;
    logic             tr, wm;
    logic             start, stop, swap, clr, fs, act, rerr;

    logic        dma_enable;
    logic [31:0] dma_base_address;
    logic [31:0] dma_total_size;
    logic [9:0]  dma_threshold;
    logic        dma_transform, dma_word_mode;
    logic        cur_buf, frame_done, overrun, err, busy;

    pixel_frame_scheduler #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_buf0_addr    (b0),
        .cfg_buf1_addr    (b1),
        .cfg_frame_bursts (bursts),
        .cfg_threshold    (thr),
        .cfg_transform    (tr),
        .cfg_word_mode    (wm),
        .cmd_start        (start),
        .cmd_stop         (stop),
        .cmd_swap         (swap),
        .cmd_err_clr      (clr),
        .frame_start      (fs),
        .dma_active       (act),
        .dma_read_error   (rerr),
        .dma_enable       (dma_enable),
        .dma_base_address (dma_base_address),
        .dma_total_size   (dma_total_size),
        .dma_threshold    (dma_threshold),
        .dma_transform    (dma_transform),
        .dma_word_mode    (dma_word_mode),
        .cur_buf          (cur_buf),
        .frame_done       (frame_done),
        .overrun          (overrun),
        .err              (err),
        .busy             (busy)
    );

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, a, e);
        end
    endtask

    task automatic chk1(input string name, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, a, e);
        end
    endtask

    task automatic clear_cmds();
        start = 0; stop = 0; swap = 0; clr = 0; fs = 0; rerr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_done) done_seen++;
    endtask

    task automatic do_reset();
        clear_cmds();
        act   = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // stim = {start,stop,swap,clr,fs,act,rerr}; exp_o = {en,busy,done,buf,err,ovr}
    typedef struct {
        logic [6:0] stim;
        int         nb;
        logic [5:0] exp_o;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(input logic [6:0] s, input int n, input logic [5:0] e);
        vec_t v;
        v.stim  = s;
        v.nb    = n;
        v.exp_o = e;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    typedef enum {M_IDLE, M_WAIT, M_RUN, M_DRAIN, M_STOP, M_ERR} mph_t;
    mph_t        m_ph;
    logic        m_en, m_buf, m_done, m_ovr, m_err, m_pend, m_prev;
    logic        m_tr, m_wm;
    logic [9:0]  m_thr;
    logic [31:0] m_base, m_size;
    int          m_left;

    task automatic model_reset();
        m_ph = M_IDLE; m_en = 0; m_buf = 0; m_done = 0; m_ovr = 0;
        m_err = 0; m_pend = 0; m_prev = 0; m_tr = 0; m_wm = 0;
        m_thr = 0; m_base = 0; m_size = 0; m_left = 0;
    endtask

    task automatic model_step();
        bit rise, live;
        rise   = act && !m_prev;
        live   = (m_ph == M_RUN) || (m_ph == M_DRAIN) || (m_ph == M_STOP);
        m_done = 0;
        if (live && fs) m_ovr = 1;
        if (swap) begin
            if (m_ph == M_IDLE || m_ph == M_WAIT) m_buf = !m_buf;
            else m_pend = 1;
        end
        if (live && rerr) begin
            m_en = 0; m_err = 1; m_ph = M_ERR;
        end else if (stop && (m_ph == M_RUN || m_ph == M_DRAIN)) begin
            m_en = 0; m_ph = M_STOP;
        end else begin
            case (m_ph)
                M_IDLE: begin
                    if (clr) begin m_err = 0; m_ovr = 0; end
                    if (start) begin
                        if (bursts == 0) m_err = 1;
                        else m_ph = M_WAIT;
                    end
                end
                M_WAIT: begin
                    if (stop) m_ph = M_IDLE;
                    else if (fs) begin
                        m_base = m_buf ? b1 : b0;
                        m_size = bursts * (wm ? 32 : 128);
                        m_thr  = thr;
                        m_tr   = tr;
                        m_wm   = wm;
                        m_left = int'(bursts);
                        m_en   = 1;
                        m_ph   = M_RUN;
                    end
                end
                M_RUN: if (rise) begin
                    m_left--;
                    if (m_left == 0) begin m_en = 0; m_ph = M_DRAIN; end
                end
                M_DRAIN: if (!act) begin
                    m_done = 1;
                    if (m_pend) m_buf = !m_buf;
                    m_pend = 0;
                    m_ph   = M_WAIT;
                end
                M_STOP: if (!act) m_ph = M_IDLE;
                M_ERR: if (clr && !act) begin
                    m_err = 0; m_ovr = 0; m_ph = M_IDLE;
                end
                default: m_ph = M_IDLE;
            endcase
        end
        m_prev = act;
    endtask

    task automatic rcycle(input int n);
        @(posedge clk);
        model_step();
        #1;
        chk1($sformatf("rnd%0d_en", n), dma_enable, m_en);
        chk($sformatf("rnd%0d_base", n), dma_base_address, m_base);
        chk($sformatf("rnd%0d_size", n), dma_total_size, m_size);
        chk($sformatf("rnd%0d_thr", n), 32'(dma_threshold), 32'(m_thr));
        chk1($sformatf("rnd%0d_tr", n), dma_transform, m_tr);
        chk1($sformatf("rnd%0d_wm", n), dma_word_mode, m_wm);
        chk1($sformatf("rnd%0d_buf", n), cur_buf, m_buf);
        chk1($sformatf("rnd%0d_done", n), frame_done, m_done);
        chk1($sformatf("rnd%0d_ovr", n), overrun, m_ovr);
        chk1($sformatf("rnd%0d_err", n), err, m_err);
        chk1($sformatf("rnd%0d_busy", n), busy, m_ph != M_IDLE);
    endtask

    initial begin
        b0 = 32'h1000; b1 = 32'h8000; bursts = 0;
        thr = 10'h155; tr = 1; wm = 0;
        do_reset();

        // reset state
        chk1("rst_en", dma_enable, 0);
        chk("rst_base", dma_base_address, 0);
        chk("rst_size", dma_total_size, 0);
        chk("rst_thr", 32'(dma_threshold), 0);
        chk1("rst_tr", dma_transform, 0);
        chk1("rst_wm", dma_word_mode, 0);
        chk1("rst_buf", cur_buf, 0);
        chk1("rst_done", frame_done, 0);
        chk1("rst_ovr", overrun, 0);
        chk1("rst_err", err, 0);
        chk1("rst_busy", busy, 0);

        // ---------------- vector table ----------------
        vt.push_back(mk(7'b1000000, 0, 6'b000010));
        vt.push_back(mk(7'b0001000, 0, 6'b000000));
        vt.push_back(mk(7'b0010000, 0, 6'b000100));
        vt.push_back(mk(7'b0010000, 0, 6'b000000));
        vt.push_back(mk(7'b1000100, 2, 6'b010000));
        vt.push_back(mk(7'b0000000, 2, 6'b010000));
        vt.push_back(mk(7'b0000100, 2, 6'b110000));
        vt.push_back(mk(7'b0000010, 2, 6'b110000));
        vt.push_back(mk(7'b0000010, 2, 6'b110000));
        vt.push_back(mk(7'b0000000, 2, 6'b110000));
        vt.push_back(mk(7'b0000010, 2, 6'b010000));
        vt.push_back(mk(7'b0000110, 2, 6'b010001));
        vt.push_back(mk(7'b0000000, 2, 6'b011001));
        vt.push_back(mk(7'b0000000, 2, 6'b010001));
        vt.push_back(mk(7'b0100000, 2, 6'b000001));
        vt.push_back(mk(7'b0001000, 2, 6'b000000));
        foreach (vt[i]) begin
            {start, stop, swap, clr, fs, act, rerr} = vt[i].stim;
            bursts = vt[i].nb[CNT_W-1:0];
            tick();
            chk1($sformatf("tbl%0d_en", i), dma_enable, vt[i].exp_o[5]);
            chk1($sformatf("tbl%0d_busy", i), busy, vt[i].exp_o[4]);
            chk1($sformatf("tbl%0d_done", i), frame_done, vt[i].exp_o[3]);
            chk1($sformatf("tbl%0d_buf", i), cur_buf, vt[i].exp_o[2]);
            chk1($sformatf("tbl%0d_err", i), err, vt[i].exp_o[1]);
            chk1($sformatf("tbl%0d_ovr", i), overrun, vt[i].exp_o[0]);
        end
        clear_cmds();
        act = 0;

        // ---------------- single frame ----------------
        do_reset();
        bursts = 4; wm = 0; thr = 10'h155; tr = 1;
        start = 1; tick(); start = 0;
        fs = 1; tick(); fs = 0;
        chk1("sf_en", dma_enable, 1);
        chk("sf_size", dma_total_size, 32'd512);
        chk("sf_base", dma_base_address, 32'h1000);
        chk("sf_thr", 32'(dma_threshold), 32'h155);
        chk1("sf_tr", dma_transform, 1);
        chk1("sf_wm", dma_word_mode, 0);
        done_seen = 0;
        for (int b = 0; b < 4; b++) begin
            act = 1; tick();
            chk1($sformatf("sf_en_b%0d", b), dma_enable, b < 3);
            repeat (9) tick();
            act = 0; tick(); tick();
        end
        chk("sf_done_cnt", done_seen, 1);
        chk1("sf_busy", busy, 1);
        chk1("sf_en_end", dma_enable, 0);

        // ---------------- swap during RUN ----------------
        fs = 1; tick(); fs = 0;
        chk("sw_base0", dma_base_address, 32'h1000);
        act = 1; tick();
        swap = 1; tick(); swap = 0;
        chk1("sw_buf_pend", cur_buf, 0);
        repeat (8) tick();
        act = 0; tick(); tick();
        for (int b = 1; b < 4; b++) begin
            act = 1; repeat (10) tick();
            act = 0; tick(); tick();
        end
        chk1("sw_buf", cur_buf, 1);
        chk("sw_done_cnt", done_seen, 2);
        fs = 1; tick(); fs = 0;
        chk1("sw_en", dma_enable, 1);
        chk("sw_base1", dma_base_address, 32'h8000);

        // ---------------- stop mid-RUN ----------------
        act = 1; tick();
        stop = 1; tick(); stop = 0;
        chk1("st_en", dma_enable, 0);
        chk1("st_busy", busy, 1);
        repeat (3) tick();
        chk1("st_busy_hold", busy, 1);
        act = 0; tick();
        chk1("st_idle", busy, 0);
        chk("st_done_cnt", done_seen, 2);

        // ---------------- read error ----------------
        start = 1; tick(); start = 0;
        fs = 1; tick(); fs = 0;
        act = 1; repeat (4) tick();
        act = 0; tick(); tick();
        act = 1; tick();
        chk1("re_en_pre", dma_enable, 1);
        rerr = 1; tick(); rerr = 0;
        chk1("re_en", dma_enable, 0);
        chk1("re_err", err, 1);
        chk1("re_busy", busy, 1);
        start = 1; tick(); start = 0;
        chk1("re_start_ign", busy, 1);
        chk1("re_start_en", dma_enable, 0);
        clr = 1; tick(); clr = 0;
        chk1("re_clr_active", err, 1);
        act = 0; tick();
        clr = 1; tick(); clr = 0;
        chk1("re_clr_err", err, 0);
        chk1("re_clr_idle", busy, 0);

        // ---------------- async reset mid-frame ----------------
        chk1("ar_buf_pre", cur_buf, 1);
        start = 1; tick(); start = 0;
        fs = 1; tick(); fs = 0;
        chk1("ar_en_pre", dma_enable, 1);
        #3 rst_n = 0;
        #1;
        chk1("ar_en", dma_enable, 0);
        chk1("ar_buf", cur_buf, 0);
        chk1("ar_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1;

        // ---------------- random run vs model ----------------
        do_reset();
        model_reset();
        begin
            int rem = 0;
            int gap = 0;
            for (int n = 0; n < 4000; n++) begin
                rcycle(n);
                clear_cmds();
                if (act) begin
                    rem--;
                    if (rem == 0) begin
                        act = 0;
                        gap = $urandom_range(1, 3);
                    end
                end else if (gap > 0) begin
                    gap--;
                end else if (dma_enable) begin
                    act = 1;
                    rem = $urandom_range(3, 6);
                end
                start = ($urandom_range(0, 30) == 0);
                stop  = ($urandom_range(0, 90) == 0);
                swap  = ($urandom_range(0, 25) == 0);
                clr   = ($urandom_range(0, 20) == 0);
                fs    = ($urandom_range(0, 40) == 0);
                rerr  = act && ($urandom_range(0, 150) == 0);
                if ($urandom_range(0, 50) == 0) begin
                    bursts = CNT_W'($urandom_range(0, 5));
                    b0     = $urandom;
                    b1     = $urandom;
                    thr    = 10'($urandom);
                    tr     = 1'($urandom);
                    wm     = 1'($urandom);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
